// File: rtl/bmc_soft_pipe_pkg.sv
// Shared constants and helper functions for the soft-decision branch metric unit.
package bmc_pkg;

   // Metric width that holds N_OUT worst-case per-bit distances without overflow.
   function automatic int unsigned metric_w(input int unsigned n_out, input int unsigned soft_w);
      return soft_w + $clog2(n_out);
   endfunction

   function automatic int unsigned soft_max(input int unsigned soft_w);
      return (32'd1 << soft_w) - 32'd1;
   endfunction

endpackage

// File: rtl/bmc_soft_pipe_if.sv
// Valid/ready symbol input and metric output bundle of the branch metric unit.
// Carries rx_erase only when BMC_ERASURE_EN is defined.
interface bmc_soft_pipe_if
   import bmc_pkg::*;
#(
   parameter int unsigned N_OUT  = 2,
   parameter int unsigned SOFT_W = 3
);
   localparam int unsigned METRIC_W = metric_w(N_OUT, SOFT_W);
   localparam int unsigned N_HYP    = 1 << N_OUT;

   logic                         in_valid;
   logic                         in_ready;
   logic [N_OUT*SOFT_W-1:0]      rx_soft;
`ifdef BMC_ERASURE_EN
   logic [N_OUT-1:0]             rx_erase;
`endif
   logic                         out_valid;
   logic                         out_ready;
   logic [N_HYP*METRIC_W-1:0]    bm_all;
   logic [METRIC_W-1:0]          bm_min;
   logic [N_OUT-1:0]             bm_min_idx;

`ifdef BMC_ERASURE_EN
   modport master (
      output in_valid, rx_soft, rx_erase, out_ready,
      input  in_ready, out_valid, bm_all, bm_min, bm_min_idx
   );
   modport slave (
      input  in_valid, rx_soft, rx_erase, out_ready,
      output in_ready, out_valid, bm_all, bm_min, bm_min_idx
   );
`else
   modport master (
      output in_valid, rx_soft, out_ready,
      input  in_ready, out_valid, bm_all, bm_min, bm_min_idx
   );
   modport slave (
      input  in_valid, rx_soft, out_ready,
      output in_ready, out_valid, bm_all, bm_min, bm_min_idx
   );
`endif

endinterface

// File: rtl/bmc_soft_pipe_min_tree.sv
// Combinational argmin over 2**N_OUT metrics; on equal metrics the lower index wins.
module bmc_min_tree #(
   parameter int unsigned N_OUT    = 2,
   parameter int unsigned METRIC_W = 4
) (
   input  logic [(1<<N_OUT)*METRIC_W-1:0] metrics,
   output logic [METRIC_W-1:0]            min_metric,
   output logic [N_OUT-1:0]               min_idx
);
   localparam int unsigned N_HYP = 1 << N_OUT;

   logic [METRIC_W-1:0] lvl_val [N_OUT+1][N_HYP];
   logic [N_OUT-1:0]    lvl_idx [N_OUT+1][N_HYP];

   always_comb begin
      for (int unsigned l = 0; l <= N_OUT; l++) begin
         for (int unsigned j = 0; j < N_HYP; j++) begin
            lvl_val[l][j] = '0;
            lvl_idx[l][j] = '0;
         end
      end
      for (int unsigned h = 0; h < N_HYP; h++) begin
         lvl_val[0][h] = metrics[h*METRIC_W +: METRIC_W];
         lvl_idx[0][h] = N_OUT'(h);
      end
      // Left operand always covers lower indices, so the right one wins only when strictly smaller.
      for (int unsigned l = 0; l < N_OUT; l++) begin
         for (int unsigned j = 0; j < (N_HYP >> (l + 1)); j++) begin
            if (lvl_val[l][2*j+1] < lvl_val[l][2*j]) begin
               lvl_val[l+1][j] = lvl_val[l][2*j+1];
               lvl_idx[l+1][j] = lvl_idx[l][2*j+1];
            end else begin
               lvl_val[l+1][j] = lvl_val[l][2*j];
               lvl_idx[l+1][j] = lvl_idx[l][2*j];
            end
         end
      end
      min_metric = lvl_val[N_OUT][0];
      min_idx    = lvl_idx[N_OUT][0];
   end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage valid/ready soft-decision branch metric unit with argmin output.
// Optional BMC_ERASURE_EN adds per-bit erasure (erased bits contribute zero distance).
module bmc_soft_pipe
   import bmc_pkg::*;
#(
   parameter int unsigned N_OUT  = 2,
   parameter int unsigned SOFT_W = 3,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   bmc_soft_pipe_if.slave   bus,
   output logic [CNT_W-1:0] sym_cnt
);
   localparam int unsigned         METRIC_W = metric_w(N_OUT, SOFT_W);
   localparam int unsigned         N_HYP    = 1 << N_OUT;
   localparam logic [SOFT_W-1:0]   MAX      = SOFT_W'(soft_max(SOFT_W));

   typedef logic [METRIC_W-1:0] metric_t;

   logic                          s1_valid_q;
   logic [N_OUT-1:0][SOFT_W-1:0]  d0_d, d1_d, d0_q, d1_q;
   logic                          out_valid_q;
   metric_t [N_HYP-1:0]           sum, bm_all_q;
   metric_t                       min_metric, bm_min_q;
   logic [N_OUT-1:0]              min_idx, bm_idx_q;
   logic [N_OUT-1:0]              erase;
   logic [CNT_W-1:0]              sym_cnt_q;
   logic                          s2_adv;
   logic                          s1_load;

`ifdef BMC_ERASURE_EN
   assign erase = bus.rx_erase;
`else
   assign erase = '0;
`endif

   assign s2_adv       = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = ~s1_valid_q | s2_adv;
   assign s1_load      = bus.in_valid & bus.in_ready;

   // Zeroing both distances makes an erased bit neutral for every hypothesis.
   always_comb begin
      d0_d = '0;
      d1_d = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (!erase[i]) begin
            d0_d[i] = bus.rx_soft[i*SOFT_W +: SOFT_W];
            d1_d[i] = MAX - bus.rx_soft[i*SOFT_W +: SOFT_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         d0_q       <= '0;
         d1_q       <= '0;
      end else begin
         if (bus.in_ready) s1_valid_q <= bus.in_valid;
         if (s1_load) begin
            d0_q <= d0_d;
            d1_q <= d1_d;
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int unsigned h = 0; h < N_HYP; h++) begin
         for (int unsigned i = 0; i < N_OUT; i++) begin
            sum[h] = sum[h] + metric_t'(h[i] ? d1_q[i] : d0_q[i]);
         end
      end
   end

   bmc_min_tree #(
      .N_OUT    (N_OUT),
      .METRIC_W (METRIC_W)
   ) u_min_tree (
      .metrics    (sum),
      .min_metric (min_metric),
      .min_idx    (min_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bm_all_q    <= '0;
         bm_min_q    <= '0;
         bm_idx_q    <= '0;
         sym_cnt_q   <= '0;
      end else begin
         if (s2_adv) out_valid_q <= s1_valid_q;
         if (s2_adv && s1_valid_q) begin
            bm_all_q <= sum;
            bm_min_q <= min_metric;
            bm_idx_q <= min_idx;
         end
         if (out_valid_q && bus.out_ready) sym_cnt_q <= sym_cnt_q + CNT_W'(1);
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.bm_all     = bm_all_q;
   assign bus.bm_min     = bm_min_q;
   assign bus.bm_min_idx = bm_idx_q;
   assign sym_cnt        = sym_cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: directed vectors, random streaming with stalls, reset and counter wrap.
module tb_bmc_soft_pipe;
   localparam int unsigned N_OUT  = 2;
   localparam int unsigned SOFT_W = 3;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned MW     = SOFT_W + 1;
   localparam int unsigned NH     = 1 << N_OUT;
   localparam int unsigned RXW    = N_OUT * SOFT_W;
   localparam int unsigned EW     = RXW + N_OUT;
   localparam int unsigned SMAX   = (1 << SOFT_W) - 1;
   localparam int unsigned HW     = 1 + NH*MW + MW + N_OUT;

   typedef logic [EW-1:0] ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bmc_soft_pipe_if #(.N_OUT(N_OUT), .SOFT_W(SOFT_W)) bus ();
   bmc_soft_pipe_if #(.N_OUT(2), .SOFT_W(1)) bus_h ();
   logic [CNT_W-1:0] sym_cnt;
   logic [1:0]       sym_cnt_h;

   bmc_soft_pipe #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .sym_cnt (sym_cnt)
   );

   bmc_soft_pipe #(.N_OUT(2), .SOFT_W(1), .CNT_W(2)) dut_h (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_h),
      .sym_cnt (sym_cnt_h)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_out_seen = 0;
   int first_out_cyc = -1;
   int last_out_cyc = -1;
   bit last_in_acc = 1'b0;
   bit stall_prev = 1'b0;
   logic [HW-1:0] held;
   ent_t sbq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Distance is |sample - ideal level| for the hypothesised bit, summed over unerased bits.
   function automatic int unsigned ref_bm(input int unsigned h, input ent_t e);
      int unsigned sum = 0;
      for (int i = 0; i < int'(N_OUT); i++) begin
         int s;
         int tgt;
         s   = int'((e >> (i*SOFT_W)) & ent_t'(SMAX));
         tgt = ((h >> i) & 1) != 0 ? int'(SMAX) : 0;
         if (((e >> (RXW + i)) & 1) == 0) sum += int'(s > tgt ? s - tgt : tgt - s);
      end
      return sum;
   endfunction

   task automatic check_output(input ent_t e);
      logic [NH*MW-1:0] exp_all;
      int unsigned best;
      int unsigned best_idx;
      int unsigned m;
      exp_all  = '0;
      best     = ref_bm(0, e);
      best_idx = 0;
      for (int unsigned h = 0; h < NH; h++) begin
         m = ref_bm(h, e);
         exp_all[h*MW +: MW] = MW'(m);
         if (m < best) begin
            best     = m;
            best_idx = h;
         end
      end
      chk("model_bm_all", 64'(bus.bm_all), 64'(exp_all));
      chk("model_bm_min", 64'(bus.bm_min), 64'(best));
      chk("model_bm_min_idx", 64'(bus.bm_min_idx), 64'(best_idx));
   endtask

   task automatic tick();
      ent_t e;
      @(negedge clk);
      last_in_acc = 1'b0;
      if (!rst) begin
         if (stall_prev) begin
            chk("stall_hold", 64'({bus.out_valid, bus.bm_all, bus.bm_min, bus.bm_min_idx}),
                64'(held));
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held       = {bus.out_valid, bus.bm_all, bus.bm_min, bus.bm_min_idx};
         if (bus.out_valid && bus.out_ready) begin
            n_out_seen++;
            last_out_cyc = cyc;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            chk("sb_nonempty", 64'(sbq.size() > 0), 64'(1));
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               check_output(e);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            last_in_acc = 1'b1;
`ifdef BMC_ERASURE_EN
            sbq.push_back({bus.rx_erase, bus.rx_soft});
`else
            sbq.push_back({N_OUT'(0), bus.rx_soft});
`endif
         end
      end else begin
         stall_prev = 1'b0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus_h.in_valid = 1'b0;
      tick();
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      chk({tag, "_sym_cnt"}, 64'(sym_cnt), 64'(0));
      sbq.delete();
      rst = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [RXW-1:0] rx,
                           input logic [NH*MW-1:0] exp_all, input int unsigned exp_min,
                           input int unsigned exp_idx);
      bus.in_valid = 1'b1;
      bus.rx_soft  = rx;
      tick();
      chk({tag, "_accept"}, 64'(last_in_acc), 64'(1));
      bus.in_valid = 1'b0;
      chk({tag, "_valid_k"}, 64'(bus.out_valid), 64'(0));
      tick();
      chk({tag, "_valid_k1"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_bm_all"}, 64'(bus.bm_all), 64'(exp_all));
      chk({tag, "_bm_min"}, 64'(bus.bm_min), 64'(exp_min));
      chk({tag, "_bm_min_idx"}, 64'(bus.bm_min_idx), 64'(exp_idx));
      tick();
   endtask

   initial begin
      int sent;
      int t;
      int c0;
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.rx_soft     = '0;
      bus.out_ready   = 1'b1;
      bus_h.in_valid  = 1'b0;
      bus_h.rx_soft   = '0;
      bus_h.out_ready = 1'b1;
`ifdef BMC_ERASURE_EN
      bus.rx_erase    = '0;
      bus_h.rx_erase  = '0;
`endif
      repeat (2) tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_sym_cnt", 64'(sym_cnt), 64'(0));
      chk("rst_bm_all", 64'(bus.bm_all), 64'(0));
      chk("rst_bm_min", 64'(bus.bm_min), 64'(0));
      chk("rst_bm_min_idx", 64'(bus.bm_min_idx), 64'(0));
      rst = 1'b0;
      tick();

      directed("soft_7_0", {3'd7, 3'd0}, {4'd7, 4'd0, 4'd14, 4'd7}, 0, 2);
      directed("soft_3_4", {3'd3, 3'd4}, {4'd7, 4'd8, 4'd6, 4'd7}, 6, 1);
`ifdef BMC_ERASURE_EN
      bus.rx_erase = 2'b10;
      directed("erase", {3'd7, 3'd0}, {4'd7, 4'd0, 4'd7, 4'd0}, 0, 0);
      bus.rx_erase = '0;
`endif
      chk("sym_cnt_directed", 64'(sym_cnt), 64'(n_out_seen));

      // Hard-decision instance: Hamming metric, then 2-bit counter wrap after 5 symbols.
      bus_h.in_valid = 1'b1;
      bus_h.rx_soft  = 2'b10;
      tick();
      bus_h.in_valid = 1'b0;
      tick();
      chk("ham_valid", 64'(bus_h.out_valid), 64'(1));
      chk("ham_bm_all", 64'(bus_h.bm_all), 64'(8'b01_00_10_01));
      chk("ham_bm_min", 64'(bus_h.bm_min), 64'(0));
      chk("ham_bm_min_idx", 64'(bus_h.bm_min_idx), 64'(2));
      bus_h.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_h.rx_soft = 2'($urandom);
         tick();
      end
      bus_h.in_valid = 1'b0;
      repeat (4) tick();
      chk("cnt_wrap", 64'(sym_cnt_h), 64'(1));

      // Back-to-back stream of 10 random symbols.
      do_reset("rst2");
      n_out_seen    = 0;
      first_out_cyc = -1;
      c0            = cyc;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.rx_soft = RXW'($urandom);
`ifdef BMC_ERASURE_EN
         bus.rx_erase = N_OUT'($urandom);
`endif
         tick();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
      chk("b2b_latency", 64'(first_out_cyc - c0), 64'(2));
      chk("b2b_consecutive", 64'(last_out_cyc - first_out_cyc), 64'(9));
      chk("b2b_count", 64'(n_out_seen), 64'(10));
      chk("b2b_sym_cnt", 64'(sym_cnt), 64'(10));

      // Stream with a 5-cycle downstream stall in the middle.
      n_out_seen   = 0;
      sent         = 0;
      t            = 0;
      bus.in_valid = 1'b1;
      bus.rx_soft  = RXW'($urandom);
      while (sent < 20 && t < 200) begin
         bus.out_ready = !(t >= 5 && t < 10);
         tick();
         t++;
         if (last_in_acc) begin
            sent++;
            bus.rx_soft = RXW'($urandom);
`ifdef BMC_ERASURE_EN
            bus.rx_erase = N_OUT'($urandom);
`endif
         end
         if (t == 9) begin
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("stall_sent", 64'(sent), 64'(20));
      for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
      chk("stall_drained", 64'(sbq.size()), 64'(0));
      chk("stall_count", 64'(n_out_seen), 64'(20));
      chk("stall_sym_cnt", 64'(sym_cnt), 64'(30));

      // Reset with two symbols in flight.
      bus.in_valid = 1'b1;
      bus.rx_soft  = RXW'($urandom);
      tick();
      bus.rx_soft  = RXW'($urandom);
      tick();
      chk("flight_out_valid", 64'(bus.out_valid), 64'(1));
      do_reset("rst3");
      n_out_seen = 0;
      repeat (4) tick();
      chk("post_rst_no_out", 64'(n_out_seen), 64'(0));
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("post_rst_sym_cnt", 64'(sym_cnt), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
